key_expansion: RTL and testbench

- Iterative, clocked AES key schedule (FIPS-197 §5.2) for AES-128/192/256, selected by parameter Nk.
- On a start pulse it latches the cipher key and generates all 4*(Nr+1) round-key words, one word per clock.
- It then presents the full schedule as one flat vector to the round datapath.
- It sits between key load logic and the AES cipher/inverse-cipher round units.

---
 rtl/key_expansion.sv | 63 ++++++
 tb/tb_key_expansion.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/key_expansion.sv
// key_expansion: iterative AES key schedule producing one 32-bit word per clock after a start pulse.
module key_expansion #(
  parameter int Nk = 8,
  parameter int Nr = Nk + 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [0:Nk*32-1]         key,
  output logic [0:128*(Nr+1)-1]    expanded_key,
  output logic                     busy,
  output logic                     done
);
  localparam int NW = 4 * (Nr + 1);
  localparam int CW = $clog2(NW + 1);
  localparam logic [0:2047] SBOX = 2048'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0_b7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275_09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf_d0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2_cd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb_e0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08_ba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e_e1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16;
  function automatic logic [7:0] sb(input logic [7:0] b);
    return SBOX[{b, 3'b000} +: 8];
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
  endfunction
  logic [CW-1:0] i, ip, ib;
  logic [2:0]    ph;
  logic [7:0]    rc;
  logic [31:0]   prev, back, temp, word;
  always_comb begin
    ip   = i - 1'b1;
    ib   = i - CW'(Nk);
    prev = expanded_key[{ip, 5'b0} +: 32];
    back = expanded_key[{ib, 5'b0} +: 32];
    temp = ph == 3'd0 ? sub_word({prev[23:0], prev[31:24]}) ^ {rc, 24'h0} :
           (Nk == 8 && ph == 3'd4) ? sub_word(prev) : prev;
    word = back ^ temp;
  end
  // ph tracks i mod Nk and rc tracks Rcon[i/Nk], avoiding a divider
  always_ff @(posedge clk) begin
    if (rst) begin
      expanded_key <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      i            <= '0;
      ph           <= '0;
      rc           <= '0;
    end else if (start && !busy) begin
      expanded_key[0 +: Nk*32] <= key;
      i    <= CW'(Nk);
      ph   <= '0;
      rc   <= 8'h01;
      busy <= 1'b1;
      done <= 1'b0;
    end else if (busy) begin
      expanded_key[{i, 5'b0} +: 32] <= word;
      i  <= i + 1'b1;
      ph <= ph == 3'(Nk - 1) ? 3'd0 : ph + 3'd1;
      if (ph == 3'd0) rc <= {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      if (i == CW'(NW - 1)) begin
        busy <= 1'b0;
        done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_key_expansion.sv
// tb_key_expansion: checks AES-128/192/256 schedules against a GF(2^8)-derived reference model.
module tb_key_expansion;
  logic clk = 0, rst = 1;
  logic start8 = 0, start6 = 0, start4 = 0;
  logic [0:255] key8 = '0;
  logic [0:191] key6 = '0;
  logic [0:127] key4 = '0;
  logic [0:1919] ek8;
  logic [0:1663] ek6;
  logic [0:1407] ek4;
  logic busy8, busy6, busy4, done8, done6, done4;
  int vectors = 0, miscompares = 0, cyc = 0, t0 = 0;
  logic [7:0] sbt [256];

  key_expansion #(.Nk(8)) u8 (.clk(clk), .rst(rst), .start(start8), .key(key8), .expanded_key(ek8), .busy(busy8), .done(done8));
  key_expansion #(.Nk(6)) u6 (.clk(clk), .rst(rst), .start(start6), .key(key6), .expanded_key(ek6), .busy(busy6), .done(done6));
  key_expansion #(.Nk(4)) u4 (.clk(clk), .rst(rst), .start(start4), .key(key4), .expanded_key(ek4), .busy(busy4), .done(done4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 0;
    for (int n = 0; n < 8; n++) begin
      if (b[0]) p ^= a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction
  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return 8'((x << n) | (x >> (8 - n)));
  endfunction
  // S-box from its definition: multiplicative inverse followed by the affine map
  function automatic logic [7:0] sbox_of(input logic [7:0] a);
    logic [7:0] inv;
    inv = 0;
    for (int c = 1; c < 256; c++) if (gmul(a, 8'(c)) == 8'h01) inv = 8'(c);
    return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
  endfunction
  function automatic logic [31:0] subw(input logic [31:0] x);
    return {sbt[x[31:24]], sbt[x[23:16]], sbt[x[15:8]], sbt[x[7:0]]};
  endfunction
  function automatic logic [7:0] rcon(input int j);
    logic [7:0] r;
    r = 8'h01;
    for (int n = 1; n < j; n++) r = xt(r);
    return r;
  endfunction
  function automatic logic [0:1919] model(input int nk, input logic [0:255] k);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [0:1919] r;
    r = '0;
    for (int n = 0; n < nk; n++) w[n] = k[32*n +: 32];
    for (int n = nk; n < 4 * (nk + 7); n++) begin
      t = w[n-1];
      if (n % nk == 0) t = subw({t[23:0], t[31:24]}) ^ {rcon(n / nk), 24'h0};
      else if (nk == 8 && n % 8 == 4) t = subw(t);
      w[n] = w[n-nk] ^ t;
    end
    for (int n = 0; n < 4 * (nk + 7); n++) r[32*n +: 32] = w[n];
    return r;
  endfunction

  function automatic logic [127:0] rk(input int nk, input int n);
    return nk == 8 ? ek8[128*n +: 128] : nk == 6 ? ek6[128*n +: 128] : ek4[128*n +: 128];
  endfunction
  function automatic logic get_done(input int nk);
    return nk == 8 ? done8 : nk == 6 ? done6 : done4;
  endfunction
  function automatic logic get_busy(input int nk);
    return nk == 8 ? busy8 : nk == 6 ? busy6 : busy4;
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic kick(input int nk, input logic [0:255] k);
    @(negedge clk);
    if (nk == 8) begin key8 = k; start8 = 1; end
    else if (nk == 6) begin key6 = k[0:191]; start6 = 1; end
    else begin key4 = k[0:127]; start4 = 1; end
    @(posedge clk); #1;
    t0 = cyc;
    @(negedge clk);
    start8 = 0; start6 = 0; start4 = 0;
  endtask
  task automatic wait_done(input int nk, input string tag);
    int n;
    n = 0;
    while (!get_done(nk) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 128'(cyc - t0), 128'(4 * (nk + 7) - nk));
    check({tag, "_busy"}, 128'(get_busy(nk)), 128'(0));
  endtask
  task automatic full(input int nk, input logic [0:255] k, input string tag);
    logic [0:1919] m;
    m = model(nk, k);
    for (int n = 0; n <= nk + 6; n++) check($sformatf("%s_rk%0d", tag, n), rk(nk, n), m[128*n +: 128]);
  endtask
  function automatic logic [0:255] rand_key();
    logic [0:255] k;
    for (int j = 0; j < 8; j++) k[32*j +: 32] = $urandom;
    return k;
  endfunction

  initial begin
    logic [0:255] k, k2;
    for (int a = 0; a < 256; a++) sbt[a] = sbox_of(8'(a));
    repeat (2) @(posedge clk);
    #1;
    for (int n = 0; n < 15; n++) check("reset_ek8", rk(8, n), '0);
    check("reset_busy", 128'({busy8, busy6, busy4}), 128'(0));
    check("reset_done", 128'({done8, done6, done4}), 128'(0));
    @(negedge clk) rst = 0;

    k = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    kick(8, k);
    check("busy_after_start", 128'(busy8), 128'(1));
    wait_done(8, "aes256");
    check("aes256_key_lo", rk(8, 0), 128'h000102030405060708090a0b0c0d0e0f);
    check("aes256_key_hi", rk(8, 1), 128'h101112131415161718191a1b1c1d1e1f);
    check("aes256_rk2", rk(8, 2), 128'ha573c29fa176c498a97fce93a572c09c);
    check("aes256_rk14", rk(8, 14), 128'h24fc79ccbf0979e9371ac23c6d68de36);
    full(8, k, "aes256_model");

    k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    kick(4, k);
    wait_done(4, "aes128a");
    check("aes128a_w4", 128'(ek4[128 +: 32]), 128'(32'ha0fafe17));
    check("aes128a_rk10", rk(4, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    full(4, k, "aes128a_model");

    k = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    kick(4, k);
    wait_done(4, "aes128b");
    check("aes128b_rk1", rk(4, 1), 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
    check("aes128b_rk10", rk(4, 10), 128'h13111d7fe3944a17f307a78b4d2b30c5);

    for (int r = 0; r < 3; r++) begin
      k = rand_key();
      kick(6, k);
      wait_done(6, "aes192_rand");
      full(6, k, "aes192_rand");
      k = rand_key();
      kick(4, k);
      wait_done(4, "aes128_rand");
      full(4, k, "aes128_rand");
    end

    k = rand_key();
    kick(4, k);
    repeat (18) @(posedge clk);
    @(negedge clk) rst = 1;
    @(posedge clk); #1;
    for (int n = 0; n < 11; n++) check("midreset_ek", rk(4, n), '0);
    check("midreset_busy", 128'(busy4), 128'(0));
    check("midreset_done", 128'(done4), 128'(0));
    @(negedge clk) rst = 0;
    k = rand_key();
    kick(4, k);
    wait_done(4, "post_reset");
    full(4, k, "post_reset");

    k = rand_key();
    k2 = rand_key();
    kick(8, k);
    repeat (10) @(posedge clk);
    @(negedge clk);
    key8 = k2;
    start8 = 1;
    @(negedge clk) start8 = 0;
    check("ignored_start_busy", 128'(busy8), 128'(1));
    wait_done(8, "ignored_start");
    full(8, k, "ignored_start");

    kick(8, k2);
    check("restart_done_drop", 128'(done8), 128'(0));
    check("restart_busy", 128'(busy8), 128'(1));
    wait_done(8, "restart");
    full(8, k2, "restart");
    repeat (5) @(posedge clk);
    #1;
    check("done_hold", 128'(done8), 128'(1));
    full(8, k2, "hold");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
